// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter: two-port arbiter in front of a single-ported data memory.
// Port 0 is the CPU load/store path, port 1 is the loader/DMA path.
// Each access takes three cycles: IDLE (sample and arbitrate), ACCESS (memory strobe)
// and RESP (done pulse to the winner).
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN to alternate the winner on
// simultaneous requests. Without it, port 0 has fixed priority.
module mips_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                win_q, win_d;          // 0 = port 0 owns the access, 1 = port 1
    logic                we_q, we_d;            // latched write enable of the winner
    logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
    logic [DATA_W-1:0]   mem_write_data_q, mem_write_data_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                gnt0_q, gnt0_d;
    logic                gnt1_q, gnt1_d;
    logic                done0_q, done0_d;
    logic                done1_q, done1_d;
    logic                mem_write_q, mem_write_d;
    logic                mem_read_q, mem_read_d;
    logic                busy_q, busy_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic                last_q, last_d;        // port granted most recently; 1 after reset so port 0 wins first
`endif

    // State and datapath registers; reset clears every strobe asynchronously so an
    // in-flight access is abandoned without waiting for the clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= S_IDLE;
            win_q            <= 1'b0;
            we_q             <= 1'b0;
            mem_address_q    <= {ADDR_W{1'b0}};
            mem_write_data_q <= {DATA_W{1'b0}};
            rdata_q          <= {DATA_W{1'b0}};
            gnt0_q           <= 1'b0;
            gnt1_q           <= 1'b0;
            done0_q          <= 1'b0;
            done1_q          <= 1'b0;
            mem_write_q      <= 1'b0;
            mem_read_q       <= 1'b0;
            busy_q           <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_q           <= 1'b1;
`endif
        end else begin
            state_q          <= state_d;
            win_q            <= win_d;
            we_q             <= we_d;
            mem_address_q    <= mem_address_d;
            mem_write_data_q <= mem_write_data_d;
            rdata_q          <= rdata_d;
            gnt0_q           <= gnt0_d;
            gnt1_q           <= gnt1_d;
            done0_q          <= done0_d;
            done1_q          <= done1_d;
            mem_write_q      <= mem_write_d;
            mem_read_q       <= mem_read_d;
            busy_q           <= busy_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_q           <= last_d;
`endif
        end
    end

    // Next-state logic: arbitrate only in IDLE, latch the winner's request, then step
    // through ACCESS and RESP for exactly one cycle each.
    always_comb begin
        state_d          = state_q;
        win_d            = win_q;
        we_d             = we_q;
        mem_address_d    = mem_address_q;
        mem_write_data_d = mem_write_data_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_d           = last_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    state_d = S_ACCESS;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    if (req0 && req1) begin
                        win_d = ~last_q;
                    end else begin
                        win_d = ~req0;
                    end
                    last_d = win_d;
`else
                    win_d = ~req0;
`endif
                    if (win_d) begin
                        we_d             = we1;
                        mem_address_d    = addr1;
                        mem_write_data_d = wdata1;
                    end else begin
                        we_d             = we0;
                        mem_address_d    = addr0;
                        mem_write_data_d = wdata0;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCESS: state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output logic: every output is registered, so its next value is decoded from the
    // upcoming state; rdata captures the memory only at the edge that ends a read ACCESS.
    always_comb begin
        gnt0_d      = (state_d != S_IDLE) && !win_d;
        gnt1_d      = (state_d != S_IDLE) && win_d;
        done0_d     = (state_d == S_RESP) && !win_d;
        done1_d     = (state_d == S_RESP) && win_d;
        mem_write_d = (state_d == S_ACCESS) && we_d;
        mem_read_d  = (state_d == S_ACCESS) && !we_d;
        busy_d      = (state_d != S_IDLE);
        if ((state_q == S_ACCESS) && !we_q) begin
            rdata_d = mem_read_data;
        end else begin
            rdata_d = rdata_q;
        end
    end

    assign gnt0           = gnt0_q;
    assign gnt1           = gnt1_q;
    assign done0          = done0_q;
    assign done1          = done1_q;
    assign rdata          = rdata_q;
    assign mem_address    = mem_address_q;
    assign mem_write_data = mem_write_data_q;
    assign mem_write      = mem_write_q;
    assign mem_read       = mem_read_q;
    assign busy           = busy_q;

endmodule
